multi_ranger: RTL

Parametrised multi-channel ultrasonic ranging controller for HC-SR04-class sensors on the GPIO header. It time-multiplexes N sensors round-robin so no two fire together. For each channel it generates the trigger pulse, times the echo and converts it to centimetres without a divider. It then publishes per-channel distance, a valid strobe, a proximity (near) flag and a timeout flag. It is the generalised successor to the single-sensor proximity path: it adds channel count, an echo timeout, and a configurable threshold and slot period.

---
 rtl/ranger_pkg.sv | 21 ++
 rtl/ranger_tick.sv | 37 +++
 rtl/multi_ranger.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/ranger_pkg.sv
// Shared types and constants for the multi-channel ultrasonic ranger.
// Holds the FSM state encoding, the echo-time-to-centimetre ratio and the tick-rate helper.
package ranger_pkg;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT,
        MEAS,
        STORE,
        GAP
    } ranger_state_t;

    // Round-trip echo time for one centimetre of range.
    localparam int US_PER_CM = 58;

    function automatic int cycles_per_us(input longint clk_hz);
        return int'(clk_hz / 64'd1_000_000);
    endfunction

endpackage

// File: rtl/ranger_tick.sv
// Free-running microsecond strobe: tick is high for one cycle every CLK_HZ/1e6 cycles.
module ranger_tick
    import ranger_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int CPU   = cycles_per_us(CLK_HZ);
    localparam int CNT_W = (CPU > 1) ? $clog2(CPU) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CPU - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == LAST);
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/multi_ranger.sv
// Round-robin HC-SR04 ranging controller for N_CH sensors: trigger, echo timing, cm conversion.
// Optional near-flag hysteresis is enabled by defining RANGER_HYST_EN.
module multi_ranger
    import ranger_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int N_CH       = 2,
    parameter int DIST_W     = 8,
    parameter int TRIG_US    = 10,
    parameter int TIMEOUT_US = 30000,
    parameter int SLOT_MS    = 60,
    parameter int NEAR_CM    = 20,
    parameter int HYST_CM    = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trig,
    output logic [N_CH*DIST_W-1:0]   distance,
    output logic [N_CH-1:0]          valid,
    output logic [N_CH-1:0]          near,
    output logic [N_CH-1:0]          timeout,
    output logic                     busy
);

    localparam int SLOT_US = SLOT_MS * 1000;
    localparam int PH_MAX  = (TIMEOUT_US > TRIG_US) ? TIMEOUT_US : TRIG_US;
    localparam int PH_W    = $clog2(PH_MAX + 1);
    localparam int SLOT_W  = $clog2(SLOT_US + 1);
    localparam int SUB_W   = $clog2(US_PER_CM);
    localparam int CH_W    = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [PH_W-1:0]   TRIG_LAST = PH_W'(TRIG_US - 1);
    localparam logic [PH_W-1:0]   TO_LAST   = PH_W'(TIMEOUT_US - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_US - 1);
    localparam logic [SUB_W-1:0]  SUB_LAST  = SUB_W'(US_PER_CM - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(N_CH - 1);
    localparam logic [DIST_W-1:0] DIST_MAX  = '1;

`ifdef RANGER_HYST_EN
    localparam int CLEAR_CM = NEAR_CM + HYST_CM;
`else
    // Zero-width band: near reduces to a plain (distance < NEAR_CM) compare.
    localparam int CLEAR_CM = NEAR_CM + 0 * HYST_CM;
`endif

    logic                   tick;
    logic [N_CH-1:0]        echo_meta_q, echo_sync_q, echo_prev_q;
    ranger_state_t          state_q, state_d;
    logic [CH_W-1:0]        ch_q, ch_d;
    logic [PH_W-1:0]        phase_q, phase_d;
    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic [SUB_W-1:0]       sub_q, sub_d;
    logic [DIST_W-1:0]      cm_q, cm_d;
    logic                   to_q, to_d;
    logic [N_CH-1:0]        trig_q, trig_d;
    logic [N_CH-1:0]        valid_q, valid_d;
    logic [N_CH-1:0]        near_q, near_d;
    logic [N_CH-1:0]        timeout_q, timeout_d;
    logic [N_CH*DIST_W-1:0] dist_q, dist_d;
    logic [N_CH-1:0]        ch_onehot;
    logic                   echo_cur, echo_rise;

    ranger_tick #(.CLK_HZ(CLK_HZ)) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // The third stage keeps the previous synchronised level so only a genuine 0->1 edge starts a measurement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_prev_q <= '0;
        end else begin
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
        end
    end

    assign ch_onehot = N_CH'(1) << ch_q;
    assign echo_cur  = echo_sync_q[ch_q];
    assign echo_rise = echo_sync_q[ch_q] & ~echo_prev_q[ch_q];

    always_comb begin
        // NOTE: every variable gets a default before the case, so no path can infer a latch.
        state_d   = state_q;
        ch_d      = ch_q;
        phase_d   = phase_q;
        slot_d    = slot_q;
        sub_d     = sub_q;
        cm_d      = cm_q;
        to_d      = to_q;
        trig_d    = '0;
        valid_d   = '0;
        near_d    = near_q;
        timeout_d = timeout_q;
        dist_d    = dist_q;

        if (tick && state_q != IDLE && slot_q != SLOT_LAST) slot_d = slot_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (en) begin
                    state_d = TRIG;
                    phase_d = '0;
                    slot_d  = '0;
                end
            end
            TRIG: begin
                trig_d = ch_onehot;
                if (tick) begin
                    if (phase_q == TRIG_LAST) begin
                        state_d = WAIT;
                        phase_d = '0;
                        to_d    = 1'b0;
                        sub_d   = '0;
                        cm_d    = '0;
                    end else begin
                        phase_d = phase_q + 1'b1;
                    end
                end
            end
            WAIT: begin
                if (tick) phase_d = phase_q + 1'b1;
                if (tick && phase_q == TO_LAST) begin
                    state_d = STORE;
                    to_d    = 1'b1;
                end else if (echo_rise) begin
                    state_d = MEAS;
                    sub_d   = tick ? SUB_W'(1) : '0;
                    cm_d    = '0;
                end
            end
            MEAS: begin
                if (tick) phase_d = phase_q + 1'b1;
                if (tick && phase_q == TO_LAST) begin
                    state_d = STORE;
                    to_d    = 1'b1;
                end else if (!echo_cur) begin
                    state_d = STORE;
                end else if (tick) begin
                    // Divider-free conversion: every US_PER_CM echo-high ticks add one saturating cm.
                    if (sub_q == SUB_LAST) begin
                        sub_d = '0;
                        if (cm_q != DIST_MAX) cm_d = cm_q + 1'b1;
                    end else begin
                        sub_d = sub_q + 1'b1;
                    end
                end
            end
            STORE: begin
                valid_d = ch_onehot;
                state_d = GAP;
                if (to_q) begin
                    dist_d[ch_q*DIST_W +: DIST_W] = DIST_MAX;
                    timeout_d[ch_q]               = 1'b1;
                    near_d[ch_q]                  = 1'b0;
                end else begin
                    dist_d[ch_q*DIST_W +: DIST_W] = cm_q;
                    timeout_d[ch_q]               = 1'b0;
                    if (int'(cm_q) < NEAR_CM)        near_d[ch_q] = 1'b1;
                    else if (int'(cm_q) >= CLEAR_CM) near_d[ch_q] = 1'b0;
                end
            end
            GAP: begin
                if (tick && slot_q == SLOT_LAST) begin
                    ch_d    = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    slot_d  = '0;
                    phase_d = '0;
                    state_d = en ? TRIG : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ch_q      <= '0;
            phase_q   <= '0;
            slot_q    <= '0;
            sub_q     <= '0;
            cm_q      <= '0;
            to_q      <= 1'b0;
            trig_q    <= '0;
            valid_q   <= '0;
            near_q    <= '0;
            timeout_q <= '0;
            dist_q    <= '0;
        end else begin
            state_q   <= state_d;
            ch_q      <= ch_d;
            phase_q   <= phase_d;
            slot_q    <= slot_d;
            sub_q     <= sub_d;
            cm_q      <= cm_d;
            to_q      <= to_d;
            trig_q    <= trig_d;
            valid_q   <= valid_d;
            near_q    <= near_d;
            timeout_q <= timeout_d;
            dist_q    <= dist_d;
        end
    end

    assign trig     = trig_q;
    assign distance = dist_q;
    assign valid    = valid_q;
    assign near     = near_q;
    assign timeout  = timeout_q;
    assign busy     = (state_q != IDLE);

endmodule
